data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Data-memory slave directly downstream of the load/store unit. Accepts the LSU request
//  (cs, wr, mask, addr, data_wr), performs byte-lane masked word writes and word reads on a
//  local array, and returns read data on data_rd. Optional wait states model slow memory:
//  stall freezes the core (PC/regfile write enable) until the access completes.
// PARAMETERS
//  ADDR_W       10             word-address width; array depth = 2**ADDR_W 32-bit words
//  WAIT_STATES  0              extra cycles per access (0..15); 0 = single-cycle memory
//  TOHOST_ADDR  32'h0000_0FF0  byte address of the tohost word (used only with DMEM_TOHOST_EN)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   reset, asynchronous, active-high
//  cs            in   1   chip select, active-low; 0 = request present
//  wr            in   1   0 = write, 1 = read (meaningful only when cs = 0)
//  mask          in   4   byte-lane write enables, bit i -> data bits [8i+7:8i]
//  addr          in   32  byte address; word index = addr[ADDR_W+1:2]
//  data_wr       in   32  lane-positioned write data
//  data_rd       out  32  read word, unshifted (LSU extracts byte/half)
//  stall         out  1   1 = access in progress, core must hold state
//  err           out  1   1 = access out of range (addr[31:ADDR_W+2] != 0)
//  tohost_valid  out  1   [DMEM_TOHOST_EN only] sticky: tohost word written
//  tohost_data   out  32  [DMEM_TOHOST_EN only] last word written to TOHOST_ADDR
// BEHAVIOUR
//  - Reset: stall=0, err=0, data_rd=0, FSM=IDLE, wait counter=0, tohost_valid=0, tohost_data=0.
//    Array contents not reset. rst mid-access: return to IDLE at once; pending write discarded.
//  - WAIT_STATES=0: no FSM. Read: data_rd = mem[idx] combinationally when cs=0 & wr=1,
//    else 0. Write: on clk edge when cs=0 & wr=0, lanes with mask[i]=1 updated. stall tied 0.
//  - WAIT_STATES>0, FSM IDLE -> WAIT -> DONE -> IDLE:
//    IDLE: on cs=0, latch addr/wr/mask/data_wr, load counter=WAIT_STATES-1, stall=1 this
//          cycle (combinational from cs), go WAIT. cs=1 -> stay, stall=0.
//    WAIT: stall=1; counter decrements each cycle; at 0 go DONE. Live inputs ignored.
//    DONE: stall=0; data_rd = mem[latched idx] for reads; write committed on this cycle's
//          clk edge; go IDLE. A request present in the following IDLE cycle starts a new access.
//    Latency: WAIT_STATES+1 cycles from request to completion, stall high for WAIT_STATES.
//  - data_rd = 0 whenever no read completes in the current cycle.
//  - err: asserted in the completion cycle only (same cycle as data_rd/commit); out-of-range
//    write is dropped, out-of-range read returns 0. stall timing unchanged by err.
//  - mask=0 write: no array change, not an error. Alignment is the LSU's job; addr[1:0] ignored.
//  - Write then read of same word in consecutive accesses returns the new data (no bypass
//    needed: write commits before the next access completes).
// CONFIGURATION
//  DMEM_TOHOST_EN defined: tohost_valid/tohost_data ports exist; a completed write whose word
//    address matches TOHOST_ADDR[31:2] loads tohost_data with the lane-merged word and sets
//    tohost_valid (sticky until rst); the array is also written. Used by compliance benches to
//    end simulation.
//  DMEM_TOHOST_EN undefined: ports and logic absent; TOHOST_ADDR is an ordinary location.
// TESTING
//  1 WAIT_STATES=0: write 32'hDEADBEEF mask 4'hF to 0x10, then read 0x10 -> data_rd=DEADBEEF same cycle, stall=0.
//  2 Byte lanes: word 0x20 = 32'h11223344; write data_wr=32'h00AA0000 mask 4'b0100 -> read 0x20 = 32'h11AA3344.
//  3 WAIT_STATES=3: read request at cycle t -> stall=1 at t..t+2, stall=0 and data valid at t+3; back-to-back reads each take 4 cycles.
//  4 Out of range (ADDR_W=10): write to 0x0000_1000 -> err=1 on completion, array unchanged; read same -> data_rd=0, err=1.
//  5 Reset mid-access: WAIT_STATES=3, write 0x5A5A5A5A, assert rst in WAIT -> stall=0 immediately, later read returns old contents.
//  6 DMEM_TOHOST_EN: write 32'h1 to TOHOST_ADDR -> tohost_valid=1, tohost_data=1 next cycle, held until rst.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl - data-memory slave behind the load/store unit.
//
// Performs byte-lane masked word writes and whole-word reads on a local 32-bit array.
// With WAIT_STATES = 0 it behaves as a single-cycle memory: reads are combinational and
// writes commit on the clock edge. With WAIT_STATES > 0 a small IDLE -> WAIT -> DONE
// sequencer holds the core on stall until the access completes. Each access takes
// WAIT_STATES + 1 cycles, and stall is high for WAIT_STATES of them.
//
// Optional feature macro: DMEM_TOHOST_EN. When it is defined, the tohost_valid and
// tohost_data ports exist. A completed write to the word at TOHOST_ADDR is captured on them.
//
// Ports
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   cs            in   1   chip select, active-low (0 = request present)
//   wr            in   1   0 = write, 1 = read
//   mask          in   4   byte-lane write enables, bit i -> data bits [8i+7:8i]
//   addr          in   32  byte address; word index = addr[ADDR_W+1:2]
//   data_wr       in   32  lane-positioned write data
//   data_rd       out  32  read word, unshifted; 0 when no read completes this cycle
//   stall         out  1   access in progress, core must hold state
//   err           out  1   completing access is out of range
//   tohost_valid  out  1   [DMEM_TOHOST_EN] sticky flag, tohost word written
//   tohost_data   out  32  [DMEM_TOHOST_EN] last word written to TOHOST_ADDR
module data_mem_ctrl #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        stall,
    output logic        err
`ifdef DMEM_TOHOST_EN
    ,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    logic [31:0] mem [DEPTH];

    // The access that completes in the current cycle. It is either the live request or
    // the request latched at the start of a slow access.
    logic              acc_valid;
    logic              acc_wr;
    logic [3:0]        acc_mask;
    logic [29:0]       acc_waddr;
    logic [31:0]       acc_data;

    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       merged;
    logic              do_write;

    // Alignment belongs to the LSU, so the byte offset is deliberately ignored.
    logic unused_lsbs;
    assign unused_lsbs = ^addr[1:0];

    generate
        if (WAIT_STATES == 0) begin : g_fast
            always_comb begin
                acc_valid = !cs && !rst;
                acc_wr    = wr;
                acc_mask  = mask;
                acc_waddr = addr[31:2];
                acc_data  = data_wr;
                stall     = 1'b0;
            end
        end else begin : g_slow
            state_e      state_q;
            logic [3:0]  cnt_q;
            logic        lat_wr;
            logic [3:0]  lat_mask;
            logic [29:0] lat_waddr;
            logic [31:0] lat_data;

            // cnt_q holds the stall cycles still owed after the current one. DONE is
            // entered when it reaches 0, so stall spans exactly WAIT_STATES cycles.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q   <= StIdle;
                    cnt_q     <= 4'd0;
                    lat_wr    <= 1'b0;
                    lat_mask  <= 4'd0;
                    lat_waddr <= 30'd0;
                    lat_data  <= 32'd0;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            if (!cs) begin
                                lat_wr    <= wr;
                                lat_mask  <= mask;
                                lat_waddr <= addr[31:2];
                                lat_data  <= data_wr;
                                cnt_q     <= 4'(WAIT_STATES - 1);
                                state_q   <= (WAIT_STATES == 1) ? StDone : StWait;
                            end
                        end
                        StWait: begin
                            cnt_q <= cnt_q - 4'd1;
                            if (cnt_q == 4'd1) begin
                                state_q <= StDone;
                            end
                        end
                        StDone: state_q <= StIdle;
                        default: state_q <= StIdle;
                    endcase
                end
            end

            // Stall is raised in the request cycle itself, directly from cs.
            always_comb begin
                stall     = (state_q == StWait) || ((state_q == StIdle) && !cs && !rst);
                acc_valid = (state_q == StDone);
                acc_wr    = lat_wr;
                acc_mask  = lat_mask;
                acc_waddr = lat_waddr;
                acc_data  = lat_data;
            end
        end
    endgenerate

    always_comb begin
        in_range = (acc_waddr[29:ADDR_W] == '0);
        idx      = acc_waddr[ADDR_W-1:0];
        merged   = mem[idx];
        for (int i = 0; i < 4; i++) begin
            if (acc_mask[i]) begin
                merged[8*i +: 8] = acc_data[8*i +: 8];
            end
        end
        do_write = acc_valid && !acc_wr && in_range;
        data_rd  = (acc_valid && acc_wr && in_range) ? mem[idx] : 32'd0;
        err      = acc_valid && !in_range;
    end

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= merged;
        end
    end

`ifdef DMEM_TOHOST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tohost_valid <= 1'b0;
            tohost_data  <= 32'd0;
        end else if (do_write && (acc_waddr == TOHOST_ADDR[31:2])) begin
            tohost_valid <= 1'b1;
            tohost_data  <= merged;
        end
    end
`else
    logic unused_tohost;
    assign unused_tohost = ^TOHOST_ADDR;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl. It runs a single-cycle instance and a
// three-wait-state instance side by side, and checks both against transaction-level models.
module tb_data_mem_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned WS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cs0, wr0, stall0, err0;
    logic [3:0]  mask0;
    logic [31:0] addr0, wdat0, rd0;
    logic        cs3, wr3, stall3, err3;
    logic [3:0]  mask3;
    logic [31:0] addr3, wdat3, rd3;
`ifdef DMEM_TOHOST_EN
    logic        tv0, tv3;
    logic [31:0] td0, td3;
`endif

    data_mem_ctrl #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .cs(cs0), .wr(wr0), .mask(mask0), .addr(addr0),
        .data_wr(wdat0), .data_rd(rd0), .stall(stall0), .err(err0)
`ifdef DMEM_TOHOST_EN
        , .tohost_valid(tv0), .tohost_data(td0)
`endif
    );

    data_mem_ctrl #(.ADDR_W(AW), .WAIT_STATES(WS)) dut3 (
        .clk(clk), .rst(rst), .cs(cs3), .wr(wr3), .mask(mask3), .addr(addr3),
        .data_wr(wdat3), .data_rd(rd3), .stall(stall3), .err(err3)
`ifdef DMEM_TOHOST_EN
        , .tohost_valid(tv3), .tohost_data(td3)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m0 [1024];
    logic [31:0] m3 [1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a[31:AW+2] == '0);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(7) == 0) begin
            a = $urandom;
            if (a[31:AW+2] == '0) a[31] = 1'b1;
        end else begin
            a = {26'd0, 4'($urandom_range(15)), 2'($urandom_range(3))};
        end
        return a;
    endfunction

    // Single-cycle model: every request completes in the cycle it is presented.
    logic [31:0] e0_rd;
    logic        e0_err;
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rd0", rd0, 32'd0);
            chk("rst_err0", {31'd0, err0}, 32'd0);
            chk("rst_stall0", {31'd0, stall0}, 32'd0);
        end else begin
            e0_rd  = (!cs0 && wr0 && in_rng(addr0)) ? m0[widx(addr0)] : 32'd0;
            e0_err = !cs0 && !in_rng(addr0);
            chk("rd0", rd0, e0_rd);
            chk("err0", {31'd0, err0}, {31'd0, e0_err});
            chk("stall0", {31'd0, stall0}, 32'd0);
            if (!cs0 && !wr0 && in_rng(addr0))
                m0[widx(addr0)] = merge(m0[widx(addr0)], wdat0, mask0);
        end
    end

    // Wait-state model: an accepted request completes WS cycles later. Inputs are
    // ignored until one idle cycle after that completion.
    bit          pend = 1'b0;
    int          cyc3 = 0;
    int          done_cyc;
    logic        p_wr;
    logic [3:0]  p_mask;
    logic [31:0] p_addr, p_data;
    logic [31:0] e3_rd;
    logic        e3_err, e3_stall;
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            chk("rst_rd3", rd3, 32'd0);
            chk("rst_err3", {31'd0, err3}, 32'd0);
            chk("rst_stall3", {31'd0, stall3}, 32'd0);
        end else begin
            cyc3++;
            e3_rd = 32'd0;
            e3_err = 1'b0;
            e3_stall = 1'b0;
            if (pend && cyc3 == done_cyc) begin
                e3_rd  = (p_wr && in_rng(p_addr)) ? m3[widx(p_addr)] : 32'd0;
                e3_err = !in_rng(p_addr);
                if (!p_wr && in_rng(p_addr))
                    m3[widx(p_addr)] = merge(m3[widx(p_addr)], p_data, p_mask);
                pend = 1'b0;
            end else if (pend) begin
                e3_stall = 1'b1;
            end else if (!cs3) begin
                pend = 1'b1;
                done_cyc = cyc3 + int'(WS);
                p_wr = wr3;
                p_mask = mask3;
                p_addr = addr3;
                p_data = wdat3;
                e3_stall = 1'b1;
            end
            chk("rd3", rd3, e3_rd);
            chk("err3", {31'd0, err3}, {31'd0, e3_err});
            chk("stall3", {31'd0, stall3}, {31'd0, e3_stall});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic c, input logic w, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d);
        cs0 = c; wr0 = w; mask0 = m; addr0 = a; wdat0 = d;
    endtask

    task automatic drv3(input logic c, input logic w, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d);
        cs3 = c; wr3 = w; mask3 = m; addr3 = a; wdat3 = d;
    endtask

    logic [31:0] old5;

    initial begin
        drv0(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        drv3(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Give every word the random traffic can touch a known value.
        for (int i = 0; i < 16; i++) begin
            drv0(1'b0, 1'b0, 4'hF, 32'(i * 4), $urandom);
            drv3(1'b0, 1'b0, 4'hF, 32'(i * 4), $urandom);
            step();
            drv0(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
            drv3(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
            step();
            step();
            step();
        end

        // Single-cycle write then read.
        drv0(1'b0, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
        step();
        drv0(1'b0, 1'b1, 4'h0, 32'h10, 32'd0);
        #3;
        chk("t1_rd", rd0, 32'hDEADBEEF);
        chk("t1_stall", {31'd0, stall0}, 32'd0);
        chk("t1_model", m0[4], 32'hDEADBEEF);
        step();

        // Single byte-lane update.
        drv0(1'b0, 1'b0, 4'hF, 32'h20, 32'h11223344);
        step();
        drv0(1'b0, 1'b0, 4'b0100, 32'h20, 32'h00AA0000);
        step();
        drv0(1'b0, 1'b1, 4'h0, 32'h22, 32'd0);
        #3;
        chk("t2_rd", rd0, 32'h11AA3344);
        step();

        // Out-of-range on the single-cycle instance.
        drv0(1'b0, 1'b0, 4'hF, 32'h1000, 32'hFFFFFFFF);
        #3;
        chk("t4_err_wr0", {31'd0, err0}, 32'd1);
        step();
        drv0(1'b0, 1'b1, 4'h0, 32'h1000, 32'd0);
        #3;
        chk("t4_rd0", rd0, 32'd0);
        chk("t4_err_rd0", {31'd0, err0}, 32'd1);
        step();
        drv0(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);

        // Wait-state timing: two back-to-back reads with cs held low throughout.
        drv3(1'b0, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
        step();
        drv3(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        step();
        step();
        step();
        drv3(1'b0, 1'b1, 4'h0, 32'h10, 32'd0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                #3;
                if (k < 3) begin
                    chk("t3_stall_hi", {31'd0, stall3}, 32'd1);
                end else begin
                    chk("t3_stall_lo", {31'd0, stall3}, 32'd0);
                    chk("t3_rd", rd3, 32'hDEADBEEF);
                end
                step();
            end
        end
        drv3(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        step();

        // Out-of-range on the wait-state instance.
        drv3(1'b0, 1'b0, 4'hF, 32'h1000, 32'hFFFFFFFF);
        step();
        drv3(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        step();
        step();
        #3;
        chk("t4_err_wr3", {31'd0, err3}, 32'd1);
        step();
        drv3(1'b0, 1'b1, 4'h0, 32'h1000, 32'd0);
        step();
        drv3(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        step();
        step();
        #3;
        chk("t4_rd3", rd3, 32'd0);
        chk("t4_err_rd3", {31'd0, err3}, 32'd1);
        step();

        // Reset during WAIT drops the pending write.
        old5 = m3[5];
        drv3(1'b0, 1'b0, 4'hF, 32'h14, 32'h5A5A5A5A);
        step();
        drv3(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_stall", {31'd0, stall3}, 32'd0);
        step();
        rst = 1'b0;
        step();
        drv3(1'b0, 1'b1, 4'h0, 32'h14, 32'd0);
        step();
        drv3(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        step();
        step();
        #3;
        chk("t5_old", rd3, old5);
        step();

        // Random traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            drv0(1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom), rnd_addr(),
                 $urandom);
            drv3(1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom), rnd_addr(),
                 $urandom);
            step();
        end
        drv0(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        drv3(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        step();
        step();
        step();
        step();

`ifdef DMEM_TOHOST_EN
        drv0(1'b0, 1'b0, 4'hF, 32'h0FF0, 32'h1);
        step();
        drv0(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
        #3;
        chk("t6_valid", {31'd0, tv0}, 32'd1);
        chk("t6_data", td0, 32'h1);
        step();
        step();
        #3;
        chk("t6_valid_held", {31'd0, tv0}, 32'd1);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
